mb_writeback: RTL
=================

# mb_writeback

Reconstructed-frame store for the intra-prediction path: accepts a reconstructed macroblock plus its macroblock number and writes it pixel by pixel into a frame-sized pixel memory. On request, it reads back the top, top-right and left neighbour pixels of any macroblock, so intra prediction draws neighbours from the reconstructed frame rather than the source image. It sits between the reconstruction adder (upstream) and the intra predictor's neighbour inputs (downstream).

## Interface
Parameters:
- `LENGTH`, 1280: frame width in pixels (pixels per line).
- `WIDTH`, 720: frame height in lines.
- `MB_SIZE_L`, 16: macroblock height in rows.
- `MB_SIZE_W`, 16: macroblock width in columns.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: `mb`/`mbnumber` valid.
- `in_ready` out 1: block can accept a macroblock.
- `mbnumber` in 13: raster index of the incoming macroblock.
- `mb` in 8 × [MB_SIZE_L*MB_SIZE_W]: pixel at row r, column c is at index r*MB_SIZE_W+c.
- `wr_done` out 1: one-cycle pulse when the write completes.
- `nb_req` in 1: neighbour fetch request.
- `nb_ready` out 1: fetch request accepted when `nb_req & nb_ready`.
- `nb_mbnumber` in 13: macroblock whose neighbours are fetched.
- `nb_valid` out 1: neighbour arrays valid; level signal.
- `toppixels` out 8 × [2*MB_SIZE_W]: top row then top-right row.
- `leftpixels` out 8 × [MB_SIZE_L]: left column, top to bottom.

## Operation
- Geometry:
  - MBS_X = LENGTH/MB_SIZE_W = 80 and MB_TOTAL = MBS_X*(WIDTH/MB_SIZE_L) = 3600.
  - mb_x = n % MBS_X and mb_y = n / MBS_X.
  - Pixel address = (mb_y*MB_SIZE_L+r)*LENGTH + mb_x*MB_SIZE_W + c, computed at a width wide enough for LENGTH*WIDTH with no truncation.
- States:
  - IDLE: `in_ready` = 1 and `nb_ready` = 1, except when `in_valid` is high; then `nb_ready` = 0 (write has priority).
  - IDLE → WRITE on an `in_valid` handshake. `mb` and `mbnumber` are captured into an internal buffer at acceptance.
  - IDLE → NBREAD on an `nb_req` handshake. `nb_valid` drops to 0 in the acceptance cycle.
  - WRITE: one pixel write per cycle in raster order within the macroblock, MB_SIZE_L*MB_SIZE_W cycles. Then `wr_done` pulses and the block returns to IDLE.
  - NBREAD: issues 2*MB_SIZE_W top reads, then MB_SIZE_L left reads. Each read is one per cycle with 1-cycle read latency. Then `nb_valid` = 1 and the block returns to IDLE.
- Neighbour reads:
  - The top row is image line mb_y*MB_SIZE_L−1.
  - The top-right row is the same line at columns MB_SIZE_W..2*MB_SIZE_W−1 relative to the macroblock origin.
  - The left column is image column mb_x*MB_SIZE_W−1.
- Neighbour availability (value 128 = unavailable):
  - mb_y = 0: all `toppixels` = 128.
  - mb_y ≠ 0 and mb_x = MBS_X−1: `toppixels[MB_SIZE_W..2*MB_SIZE_W−1]` = `toppixels[MB_SIZE_W−1]` (replicate).
  - mb_x = 0: all `leftpixels` = 128.
  - Unavailable reads still consume their cycle, so latency is constant.
- Out-of-range `mbnumber` (≥ MB_TOTAL):
  - Write: no memory access, same timing, `wr_done` still pulses.
  - Neighbour fetch: all outputs = 128, same timing.
- Outputs hold their value until the next accepted fetch.
- Memory contents are not reset.

## Timing
- Reset values: `in_ready`=0 while `reset` is high, 1 from the first cycle after release; `nb_ready`=0 while `reset` is high, then IDLE rule; `wr_done`=0; `nb_valid`=0; all `toppixels` and `leftpixels` = 128.
- Write: accept in cycle 0, writes in cycles 1..256, `wr_done` high in cycle 257. `in_ready` and `nb_ready` are 1 again in cycle 257.
- Fetch: accept in cycle 0, reads in cycles 1..48, last data in cycle 49, `nb_valid` high from cycle 50. Latency = 2*MB_SIZE_W+MB_SIZE_L+2.
- `in_ready` and `nb_ready` are 0 throughout WRITE and NBREAD; no back-to-back acceptance until the block is in IDLE.
- Reset mid-operation aborts immediately. Partial writes remain in memory, and no `wr_done` or `nb_valid` is produced for the aborted operation.

## Structure
- The shared package `intra_pkg` holds: LENGTH, WIDTH, MB_SIZE_L, MB_SIZE_W defaults; MBS_X; MB_TOTAL; PIX_UNAVAIL = 8'd128; the state enum {IDLE, WRITE, NBREAD}; the address-width localparam.
- One sub-module, `frame_mem`: single-port LENGTH*WIDTH × 8 RAM with synchronous read (1-cycle latency) and write enable. It has no reset.

## Test plan
- Write MB 0 with pixel = r*16+c, then fetch MB 1 → `leftpixels[r]` = r*16+15; all `toppixels` = 128; `nb_valid` at cycle 50.
- Write MB 0 (r*16+c) and MB 1 (value 200 everywhere), then fetch MB 80 → `toppixels[0..15]` = 240..255; `toppixels[16..31]` = 200; `leftpixels` all 128.
- Write MB 79 with bottom row = 77, then fetch MB 159 → `toppixels[0..31]` all 77, with the top-right replicated from `toppixels[15]`.
- Assert `in_valid` and `nb_req` together in IDLE → write accepted; `nb_ready` = 0 until cycle 257; the fetch is then accepted and returns the just-written data.
- Assert `reset` at cycle 100 of a write → no `wr_done`; `in_ready` = 1 in the cycle after release; `toppixels` = 128 and `nb_valid` = 0.
- Write with `mbnumber` = 3600 → `wr_done` at cycle 257; memory unchanged, verified by a fetch of MB 3599.

Source files
------------

// File: rtl/intra_pkg.sv
// -----------------------------------------------------------------------------
// intra_pkg
// Shared definitions for the intra-prediction reconstructed-frame path: default
// frame/macroblock geometry, derived macroblock counts, the "unavailable"
// neighbour value, the frame address width and the writeback state encoding.
// -----------------------------------------------------------------------------
package intra_pkg;

   localparam int LENGTH    = 1280;  // pixels per line
   localparam int WIDTH     = 720;   // lines per frame
   localparam int MB_SIZE_L = 16;    // macroblock rows
   localparam int MB_SIZE_W = 16;    // macroblock columns

   localparam int MBS_X    = LENGTH / MB_SIZE_W;
   localparam int MB_TOTAL = MBS_X * (WIDTH / MB_SIZE_L);

   // Wide enough to address every pixel of the frame without truncation.
   localparam int ADDR_W = $clog2(LENGTH * WIDTH);

   localparam int MBNUM_W = 13;

   localparam logic [7:0] PIX_UNAVAIL = 8'd128;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      NBREAD
   } wb_state_e;

endpackage

// File: rtl/mb_writeback_if.sv
// -----------------------------------------------------------------------------
// mb_writeback_if
// Macroblock write port plus neighbour-fetch port of the reconstructed-frame
// store. The slave modport is the store; the master modport is the
// reconstruction adder / intra predictor side.
//   in_valid/in_ready, mbnumber, mb : macroblock write handshake and payload
//   wr_done                          : one-cycle pulse when a write finishes
//   nb_req/nb_ready, nb_mbnumber     : neighbour fetch handshake
//   nb_valid, toppixels, leftpixels  : neighbour results (level-valid)
// -----------------------------------------------------------------------------
interface mb_writeback_if #(
   parameter int MB_SIZE_L = intra_pkg::MB_SIZE_L,
   parameter int MB_SIZE_W = intra_pkg::MB_SIZE_W
);
   logic                                   in_valid;
   logic                                   in_ready;
   logic [intra_pkg::MBNUM_W-1:0]          mbnumber;
   logic [MB_SIZE_L*MB_SIZE_W-1:0][7:0]    mb;
   logic                                   wr_done;
   logic                                   nb_req;
   logic                                   nb_ready;
   logic [intra_pkg::MBNUM_W-1:0]          nb_mbnumber;
   logic                                   nb_valid;
   logic [2*MB_SIZE_W-1:0][7:0]            toppixels;
   logic [MB_SIZE_L-1:0][7:0]              leftpixels;

   modport slave (
      input  in_valid, mbnumber, mb, nb_req, nb_mbnumber,
      output in_ready, wr_done, nb_ready, nb_valid, toppixels, leftpixels
   );

   modport master (
      output in_valid, mbnumber, mb, nb_req, nb_mbnumber,
      input  in_ready, wr_done, nb_ready, nb_valid, toppixels, leftpixels
   );
endinterface

// File: rtl/mb_writeback_frame_mem.sv
// -----------------------------------------------------------------------------
// frame_mem
// Single-port frame pixel RAM, DEPTH x 8, synchronous read (data appears the
// cycle after the address) and synchronous write.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : pixel address (read and write share it)
//   wdata_i : write pixel
//   rdata_o : pixel read at the previous cycle's address
// -----------------------------------------------------------------------------
module frame_mem #(
   parameter int DEPTH = intra_pkg::LENGTH * intra_pkg::WIDTH,
   parameter int AW    = intra_pkg::ADDR_W
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [7:0]    wdata_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];

   // NOTE: storage arrays carry no reset; clearing them would need a reset
   // port into every RAM bit and frame contents are never assumed valid
   // before they are written. Sequential state always uses non-blocking
   // assignment so every reader in the same edge sees the old value.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
   end

endmodule

// File: rtl/mb_writeback.sv
// -----------------------------------------------------------------------------
// mb_writeback
// Reconstructed-frame store: writes accepted macroblocks pixel by pixel into a
// frame RAM and, on request, reads back the top, top-right and left neighbour
// pixels of a macroblock (substituting 128 where a neighbour does not exist).
//   clk   : clock
//   reset : asynchronous, active-high
//   bus   : mb_writeback_if.slave (write and neighbour-fetch ports)
// -----------------------------------------------------------------------------
module mb_writeback #(
   parameter int LENGTH    = intra_pkg::LENGTH,
   parameter int WIDTH     = intra_pkg::WIDTH,
   parameter int MB_SIZE_L = intra_pkg::MB_SIZE_L,
   parameter int MB_SIZE_W = intra_pkg::MB_SIZE_W
) (
   input logic           clk,
   input logic           reset,
   mb_writeback_if.slave bus
);
   import intra_pkg::*;

   localparam int MB_COLS  = LENGTH / MB_SIZE_W;
   localparam int MB_COUNT = MB_COLS * (WIDTH / MB_SIZE_L);
   localparam int AW       = $clog2(LENGTH * WIDTH);
   localparam int MB_PIX   = MB_SIZE_L * MB_SIZE_W;
   localparam int N_TOP    = 2 * MB_SIZE_W;
   localparam int N_READS  = N_TOP + MB_SIZE_L;
   localparam int PW       = $clog2(MB_PIX);
   localparam int CW       = $clog2((MB_PIX > N_READS + 1) ? MB_PIX : N_READS + 1);

   wb_state_e                  state_q;
   logic [CW-1:0]              cnt_q;
   logic                       in_ready_q, wr_done_q, nb_valid_q;
   logic                       in_range_q;
   logic [MBNUM_W-1:0]         mb_x_q, mb_y_q;
   logic [MB_PIX-1:0][7:0]     mb_buf_q;
   logic [N_TOP-1:0][7:0]      top_q;
   logic [MB_SIZE_L-1:0][7:0]  left_q;

   logic                       wr_accept, nb_accept;
   logic [MBNUM_W-1:0]         acc_num, acc_x, acc_y;
   logic                       acc_in_range;

   logic                       mem_we_d;
   logic [AW-1:0]              mem_addr_d;
   logic [7:0]                 mem_wdata_d, mem_rdata;
   int                         cap_slot;
   logic [7:0]                 cap_pix;

   // Write wins when both requests arrive together in IDLE.
   assign wr_accept = in_ready_q & bus.in_valid;
   assign nb_accept = in_ready_q & ~bus.in_valid & bus.nb_req;

   assign acc_num      = bus.in_valid ? bus.mbnumber : bus.nb_mbnumber;
   assign acc_x        = MBNUM_W'(int'(acc_num) % MB_COLS);
   assign acc_y        = MBNUM_W'(int'(acc_num) / MB_COLS);
   assign acc_in_range = int'(acc_num) < MB_COUNT;

   // Fetch slot s: 0..N_TOP-1 top/top-right row, then the left column.
   function automatic logic slot_avail(input int s);
      if (!in_range_q) return 1'b0;
      if (s < N_TOP) begin
         return (mb_y_q != '0) && !(s >= MB_SIZE_W && int'(mb_x_q) == MB_COLS - 1);
      end
      return mb_x_q != '0;
   endfunction

   // Right-most column: top-right copies the last top pixel.
   function automatic logic top_replicate(input int s);
      return in_range_q && (mb_y_q != '0) && (int'(mb_x_q) == MB_COLS - 1) &&
             (s >= MB_SIZE_W) && (s < N_TOP);
   endfunction

   // NOTE: every variable driven here gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      int line, col, slot;
      mem_we_d    = 1'b0;
      mem_wdata_d = '0;
      line        = 0;
      col         = 0;
      slot        = int'(cnt_q);
      case (state_q)
         WRITE: begin
            line        = int'(mb_y_q) * MB_SIZE_L + slot / MB_SIZE_W;
            col         = int'(mb_x_q) * MB_SIZE_W + slot % MB_SIZE_W;
            mem_we_d    = in_range_q;
            mem_wdata_d = mb_buf_q[cnt_q[PW-1:0]];
         end
         NBREAD: begin
            // Unavailable slots still burn their cycle; the address is unused.
            if (slot < N_READS && slot_avail(slot)) begin
               if (slot < N_TOP) begin
                  line = int'(mb_y_q) * MB_SIZE_L - 1;
                  col  = int'(mb_x_q) * MB_SIZE_W + slot;
               end else begin
                  line = int'(mb_y_q) * MB_SIZE_L + slot - N_TOP;
                  col  = int'(mb_x_q) * MB_SIZE_W - 1;
               end
            end
         end
         default: ;
      endcase
      mem_addr_d = AW'(line * LENGTH + col);
   end

   // Read data lags the address by one cycle, so count n captures slot n-1.
   always_comb begin
      cap_slot = int'(cnt_q) - 1;
      if (top_replicate(cap_slot)) begin
         cap_pix = top_q[MB_SIZE_W-1];
      end else if (slot_avail(cap_slot)) begin
         cap_pix = mem_rdata;
      end else begin
         cap_pix = PIX_UNAVAIL;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mb_buf_q <= bus.mb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         wr_done_q  <= 1'b0;
         nb_valid_q <= 1'b0;
         in_range_q <= 1'b0;
         mb_x_q     <= '0;
         mb_y_q     <= '0;
         top_q      <= {N_TOP{PIX_UNAVAIL}};
         left_q     <= {MB_SIZE_L{PIX_UNAVAIL}};
      end else begin
         wr_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               cnt_q      <= '0;
               if (wr_accept || nb_accept) begin
                  in_ready_q <= 1'b0;
                  in_range_q <= acc_in_range;
                  mb_x_q     <= acc_x;
                  mb_y_q     <= acc_y;
               end
               if (wr_accept) begin
                  state_q <= WRITE;
               end else if (nb_accept) begin
                  state_q    <= NBREAD;
                  nb_valid_q <= 1'b0;
               end
            end
            WRITE: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(MB_PIX - 1)) begin
                  state_q    <= IDLE;
                  wr_done_q  <= 1'b1;
                  in_ready_q <= 1'b1;
               end
            end
            NBREAD: begin
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q != '0) begin
                  for (int i = 0; i < N_TOP; i++) begin
                     if (cap_slot == i) top_q[i] <= cap_pix;
                  end
                  for (int i = 0; i < MB_SIZE_L; i++) begin
                     if (cap_slot == N_TOP + i) left_q[i] <= cap_pix;
                  end
               end
               if (cnt_q == CW'(N_READS)) begin
                  state_q    <= IDLE;
                  nb_valid_q <= 1'b1;
                  in_ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   frame_mem #(
      .DEPTH (LENGTH * WIDTH),
      .AW    (AW)
   ) u_frame_mem (
      .clk     (clk),
      .we_i    (mem_we_d),
      .addr_i  (mem_addr_d),
      .wdata_i (mem_wdata_d),
      .rdata_o (mem_rdata)
   );

   assign bus.in_ready   = in_ready_q;
   assign bus.nb_ready   = in_ready_q & ~bus.in_valid;
   assign bus.wr_done    = wr_done_q;
   // Old results are marked stale in the very cycle a new fetch is accepted.
   assign bus.nb_valid   = nb_valid_q & ~nb_accept;
   assign bus.toppixels  = top_q;
   assign bus.leftpixels = left_q;

endmodule
